// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them to instruction memory, then starts the CPU.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked before the CPU is released.
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [7:0]        byte_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [31:0]       wdata_o,
   output logic              start_o,
   output logic              err_o,
   output logic [ADDR_W:0]   words_o
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t PayloadEnd = S_CHK;
`else
   localparam state_t PayloadEnd = S_DONE;
`endif

   state_t            state_q, state_d;
   logic [15:0]       count_q;
   logic [15:0]       countFull;
   logic [1:0]        byteIdx_q;
   logic [23:0]       asm_q;
   logic [ADDR_W:0]   words_q;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic              start_q;
   logic              err_q;
   logic              accept;
   logic              wordDone;
   logic              lastWord;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        xor_q;
`endif

   assign accept    = valid_i && ready_o;
   assign countFull = {byte_i, count_q[7:0]};
   assign wordDone  = (byteIdx_q == 2'd3);
   assign lastWord  = ((32'(words_q) + 32'd1) == 32'(count_q));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_HDR0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            S_HDR0: state_d = S_HDR1;
            S_HDR1: begin
               if (32'(countFull) > 32'(DEPTH)) begin
                  state_d = S_ERR;
               end else if (countFull == 16'd0) begin
                  state_d = PayloadEnd;
               end else begin
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (wordDone && lastWord) begin
                  state_d = PayloadEnd;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: state_d = (byte_i == xor_q) ? S_DONE : S_ERR;
`endif
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      ready_o = (state_q != S_DONE) && (state_q != S_ERR);
   end

   // Byte lanes shift down so the first three bytes of a word sit LSB-first beneath the fourth.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q   <= '0;
         byteIdx_q <= '0;
         asm_q     <= '0;
         words_q   <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q     <= '0;
`endif
      end else begin
         we_q    <= 1'b0;
         start_q <= (state_q == S_DONE);
         err_q   <= (state_q == S_ERR);
         if (accept) begin
            unique case (state_q)
               S_HDR0: count_q[7:0]  <= byte_i;
               S_HDR1: count_q[15:8] <= byte_i;
               S_LOAD: begin
                  if (wordDone) begin
                     we_q    <= 1'b1;
                     waddr_q <= words_q[ADDR_W-1:0];
                     wdata_q <= {byte_i, asm_q};
                     words_q <= words_q + (ADDR_W+1)'(1);
                  end else begin
                     asm_q <= {byte_i, asm_q[23:8]};
                  end
                  byteIdx_q <= byteIdx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_q <= xor_q ^ byte_i;
`endif
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign start_o = start_q;
   assign err_o   = err_q;
   assign words_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-count based reference model is compared against the DUT every cycle.
// Honours IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic              clk_i   = 1'b0;
   logic              rst_n_i = 1'b0;
   logic [7:0]        byte_i  = 8'h00;
   logic              valid_i = 1'b0;
   logic              ready_o;
   logic              we_o;
   logic [ADDR_W-1:0] waddr_o;
   logic [31:0]       wdata_o;
   logic              start_o;
   logic              err_o;
   logic [ADDR_W:0]   words_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: position in the stream decides everything
   int                k;
   int                n;
   int                term;
   logic [31:0]       acc;
   logic [7:0]        xr;
   logic              expWe, expStart, expErr, expReady;
   logic [ADDR_W-1:0] expAddr;
   logic [31:0]       expData;
   logic [ADDR_W:0]   expWords;

   logic [7:0]  stream[$];
   logic [31:0] words[$];
   int          logAddr[$];
   logic [31:0] logData[$];

   always #5 clk_i = ~clk_i;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .byte_i  (byte_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .we_o    (we_o),
      .waddr_o (waddr_o),
      .wdata_o (wdata_o),
      .start_o (start_o),
      .err_o   (err_o),
      .words_o (words_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      k = 0; n = 0; term = 0; acc = '0; xr = '0;
      expWe = 1'b0; expStart = 1'b0; expErr = 1'b0; expReady = 1'b1;
      expAddr = '0; expData = '0; expWords = '0;
   endtask

   // Predicts the outputs that follow the coming rising edge from the inputs held during this cycle
   task automatic modelStep();
      int   p;
      logic nStart, nErr, nWe;
      nStart = (term == 1);
      nErr   = (term == 2);
      nWe    = 1'b0;
      if (valid_i && term == 0) begin
         if (k == 0) begin
            n = int'(byte_i);
         end else if (k == 1) begin
            n = n | (int'(byte_i) << 8);
            if (n > DEPTH) term = 2;
            else if (n == 0 && !CK) term = 1;
         end else begin
            p = k - 2;
            if (p < 4 * n) begin
               acc = acc | (32'(byte_i) << (8 * (p % 4)));
               xr  = xr ^ byte_i;
               if (p % 4 == 3) begin
                  nWe      = 1'b1;
                  expAddr  = ADDR_W'(p / 4);
                  expData  = acc;
                  expWords = (ADDR_W+1)'(p / 4 + 1);
                  acc      = '0;
                  if (p == 4 * n - 1 && !CK) term = 1;
               end
            end else begin
               term = (byte_i == xr) ? 1 : 2;
            end
         end
         k++;
      end
      expWe    = nWe;
      expStart = nStart;
      expErr   = nErr;
      expReady = (term == 0);
   endtask

   initial begin
      modelReset();
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) modelReset();
         checkOutput("ready", 32'(ready_o), 32'(expReady));
         checkOutput("we",    32'(we_o),    32'(expWe));
         checkOutput("waddr", 32'(waddr_o), 32'(expAddr));
         checkOutput("wdata", wdata_o,      expData);
         checkOutput("start", 32'(start_o), 32'(expStart));
         checkOutput("err",   32'(err_o),   32'(expErr));
         checkOutput("words", 32'(words_o), 32'(expWords));
         if (we_o === 1'b1) begin
            logAddr.push_back(int'(waddr_o));
            logData.push_back(wdata_o);
         end
         if (rst_n_i) modelStep();
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   task automatic drive(input logic v, input logic [7:0] b);
      @(posedge clk_i);
      #2;
      valid_i = v;
      byte_i  = b;
   endtask

   task automatic doReset();
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      rst_n_i = 1'b1;
      logAddr.delete();
      logData.delete();
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) drive(1'b0, 8'($urandom));
   endtask

   task automatic buildStream(input int hdr, input bit badCk);
      logic [7:0]  x;
      logic [31:0] w;
      logic [15:0] h;
      x = 8'h00;
      h = 16'(hdr);
      stream.delete();
      stream.push_back(h[7:0]);
      stream.push_back(h[15:8]);
      foreach (words[i]) begin
         w = words[i];
         for (int b = 0; b < 4; b++) begin
            stream.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
         end
      end
      if (CK) stream.push_back(badCk ? (x ^ 8'h01) : x);
   endtask

   task automatic applyStimulus(input bit altGap, input int gapPct, input int maxBytes);
      for (int i = 0; i < stream.size() && i < maxBytes; i++) begin
         if (altGap) drive(1'b0, 8'($urandom));
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gapPct; g++) drive(1'b0, 8'($urandom));
         drive(1'b1, stream[i]);
      end
   endtask

   // Last byte is on the bus; start must stay low after its edge and be high one edge later
   task automatic checkStartTiming(input string name);
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput({name, "_start_early"}, 32'(start_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput({name, "_start_2edges"}, 32'(start_o), 32'd1);
   endtask

   task automatic checkLog(input string name);
      checkOutput({name, "_nwrites"}, 32'(logData.size()), 32'(words.size()));
      for (int i = 0; i < logData.size() && i < words.size(); i++) begin
         checkOutput({name, "_addr"}, 32'(logAddr[i]), 32'(i));
         checkOutput({name, "_data"}, logData[i], words[i]);
      end
   endtask

   initial begin
      int  nr;
      int  kind;
      bit  trunc;
      bit  badCk;
      int  cut;

      // Reset mid-load, then a clean one-word program
      doReset();
      words = '{32'h00500093};
      buildStream(1, 1'b0);
      applyStimulus(1'b0, 0, 4);
      doReset();
      applyStimulus(1'b0, 0, 1000);
      checkStartTiming("t1");
      idle(2);
      checkLog("t1");
      checkOutput("t1_words", 32'(words_o), 32'd1);
      checkOutput("t1_err", 32'(err_o), 32'd0);

      // Back-to-back three-word program
      doReset();
      words = '{32'h00000013, 32'h00100093, 32'hFFF00113};
      buildStream(3, 1'b0);
      applyStimulus(1'b0, 0, 1000);
      checkStartTiming("t2");
      checkLog("t2");
      checkOutput("t2_ready", 32'(ready_o), 32'd0);
      checkOutput("t2_words", 32'(words_o), 32'd3);

      // Same program with valid_i low every other cycle
      doReset();
      applyStimulus(1'b1, 0, 1000);
      checkStartTiming("t3");
      idle(3);
      checkLog("t3");
      checkOutput("t3_words", 32'(words_o), 32'd3);

      // Empty program
      doReset();
      words.delete();
      buildStream(0, 1'b0);
      applyStimulus(1'b0, 0, 1000);
      checkStartTiming("t4");
      checkLog("t4");
      checkOutput("t4_words", 32'(words_o), 32'd0);

      // Oversized header, trailing bytes must be ignored
      doReset();
      words.delete();
      buildStream(257, 1'b0);
      for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
      applyStimulus(1'b0, 0, 1000);
      idle(3);
      checkLog("t5");
      checkOutput("t5_err", 32'(err_o), 32'd1);
      checkOutput("t5_ready", 32'(ready_o), 32'd0);
      checkOutput("t5_start", 32'(start_o), 32'd0);
      checkOutput("t5_words", 32'(words_o), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      doReset();
      stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
      words  = '{32'h00500093};
      applyStimulus(1'b0, 0, 1000);
      checkStartTiming("t6");
      checkLog("t6");
      checkOutput("t6_err", 32'(err_o), 32'd0);

      doReset();
      stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
      applyStimulus(1'b0, 0, 1000);
      idle(3);
      checkLog("t7");
      checkOutput("t7_err", 32'(err_o), 32'd1);
      checkOutput("t7_start", 32'(start_o), 32'd0);
`endif

      // Randomized streams; the first one fills memory exactly to DEPTH
      for (int it = 0; it < 40; it++) begin
         doReset();
         words.delete();
         kind  = int'($urandom_range(9));
         trunc = ($urandom_range(4) == 0);
         badCk = ($urandom_range(3) == 0);
         if (it == 0) begin
            nr = DEPTH; trunc = 1'b0;
         end else if (kind == 0) begin
            nr = int'($urandom_range(65535, DEPTH + 1));
         end else if (kind == 1) begin
            nr = 0;
         end else begin
            nr = int'($urandom_range(6, 1));
         end
         if (nr <= DEPTH) begin
            for (int i = 0; i < nr; i++) words.push_back($urandom);
         end
         buildStream(nr, badCk);
         cut = trunc ? int'($urandom_range(stream.size() - 1)) : stream.size();
         if (!trunc) begin
            for (int i = 0; i < int'($urandom_range(3)); i++) stream.push_back(8'($urandom));
            cut = stream.size();
         end
         applyStimulus(1'b0, (it == 0) ? 0 : int'($urandom_range(60)), cut);
         idle(4);
         if (!trunc && nr <= DEPTH) begin
            checkLog("rand");
            checkOutput("rand_done", 32'(start_o | err_o), 32'd1);
         end
      end

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined CPU. Receives a byte stream (length header plus little-endian instruction words) over a valid/ready handshake, writes each assembled 32-bit word into instruction memory through a write port, then raises the CPU start signal. It replaces software preloading with a hardware load path: it writes the memory the CPU fetch path reads, and it releases the CPU only once the program is fully written.

## Interface
Parameters:
- DEPTH, 256, instruction-memory depth in 32-bit words
- ADDR_W, 8, word-address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- byte_i  in  8  stream byte
- valid_i  in  1  byte_i is valid
- ready_o  out  1  loader accepts the byte; handshake occurs when valid_i && ready_o at a rising edge
- we_o  out  1  instruction-memory write strobe, one-cycle pulse per word
- waddr_o  out  ADDR_W  word address for the write
- wdata_o  out  32  word data for the write
- start_o  out  1  CPU start; held high once the load completes
- err_o  out  1  sticky load error
- words_o  out  ADDR_W+1  count of words written so far

## Operation
- Stream format: 2-byte word count N, low byte first. Then N words of 4 bytes each, least-significant byte first. With IMEM_LOADER_CHECKSUM_EN defined, one trailing checksum byte follows the words.
- States:
  - HDR0: capture N[7:0]; go to HDR1.
  - HDR1: capture N[15:8]. Then:
    - N > DEPTH: go to ERR.
    - N == 0: go to CHK if checksum is enabled, otherwise DONE.
    - otherwise: go to LOAD.
  - LOAD: shift bytes into the assembly register. On the 4th byte, the assembled word is written at address words_o; words_o increments; byte index wraps to 0. After the byte completing word N, go to CHK (checksum enabled) or DONE.
  - CHK: compare the received byte with the XOR of all payload bytes. Equal: go to DONE. Unequal: go to ERR.
  - DONE: terminal; start_o=1.
  - ERR: terminal; err_o=1, start_o stays 0.
- The header bytes are not included in the checksum.
- ready_o = 1 in HDR0, HDR1, LOAD and CHK; ready_o = 0 in DONE and ERR. Bytes offered in DONE or ERR are ignored.
- Gaps in valid_i are allowed at any point; state and partial words are held.
- Leaving DONE or ERR requires reset. There is no other restart.
- Reset, including reset asserted mid-load:
  - state returns to HDR0 and the partial word is discarded;
  - outputs: ready_o=1, we_o=0, waddr_o=0, wdata_o=0, start_o=0, err_o=0, words_o=0.
  - Already-written memory words are not cleared.

## Timing
- we_o, waddr_o and wdata_o are registered. If the 4th byte of a word is accepted at edge E, the write is presented in the cycle following E, for exactly one cycle.
- start_o and err_o are registered from the state. They rise one cycle after entry to DONE or ERR, i.e. two edges after the final accepted byte. Consequence: start_o is never high in the same cycle as we_o.
- Throughput: one byte per cycle sustained; no back-pressure inside LOAD.
- words_o updates on the same edge that raises we_o. It saturates at N and never exceeds DEPTH.
- Width rules:
  - N is 16 bits, compared unsigned against DEPTH.
  - waddr_o = words_o[ADDR_W-1:0] at write time.
  - The checksum is an 8-bit XOR.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CHK state present; trailing checksum byte required.
  - A mismatch ends in ERR with start_o=0. All N words are still written before the check.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No CHK state and no XOR accumulator.
  - The stream ends after word N.
  - err_o can only be set by N > DEPTH.

## Test plan
- Reset mid-load: assert rst_n_i low after 2 payload bytes, release, then send the stream 01 00 | 93 00 50 00 -> single write waddr=0, wdata=0x00500093; start_o=1 two edges after the last byte; words_o=1.
- Back-to-back load: N=3, words 0x00000013, 0x00100093, 0xFFF00113, valid_i held high -> we_o pulses at addresses 0, 1, 2 with those values; start_o=1 and ready_o=0 after the last byte.
- Gapped valid_i: the same 3-word stream with valid_i low every other cycle -> identical writes; no extra we_o pulses.
- N=0: send 00 00 (plus checksum 00 if enabled) -> no writes; start_o=1; words_o=0.
- Overflow: header 01 01 (N=257, DEPTH=256) -> err_o=1, ready_o=0, start_o=0, no writes; further bytes ignored.
- Checksum (IMEM_LOADER_CHECKSUM_EN): N=1, word 0x00500093, checksum 0xC3 -> start_o=1. Same stream with checksum 0xC2 -> word written at address 0, err_o=1, start_o stays 0.
